// File: rtl/array_fifo_ctrl.sv
// FIFO pointer/flag controller wrapped around an external array.
// Holds pointers and occupancy only; data lives in the array.
module array_fifo_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int ADDR  = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             mem_write_en,
  output logic [ADDR-1:0]  mem_write_addr,
  output logic [WIDTH-1:0] mem_write_data,
  output logic [ADDR-1:0]  mem_read_addr,
  input  logic [WIDTH-1:0] mem_read_data,
  output logic [ADDR:0]    count,
  output logic             full,
  output logic             empty
);

  localparam logic [ADDR:0]   FULL_CNT = (ADDR+1)'(DEPTH);
  localparam logic [ADDR-1:0] LAST     = ADDR'(DEPTH-1);

  logic [ADDR-1:0] wr_ptr;
  logic [ADDR-1:0] rd_ptr;
  logic [ADDR:0]   cnt;
  logic            push;
  logic            pop;

  // handshake decode and array hookup
  always_comb begin
    full           = (cnt == FULL_CNT);
    empty          = (cnt == '0);
    in_ready       = !full && !flush;
    out_valid      = !empty && !flush;
    push           = in_valid && in_ready;
    pop            = out_valid && out_ready;
    mem_write_en   = push;
    mem_write_addr = wr_ptr;
    mem_write_data = in_data;
    mem_read_addr  = rd_ptr;
    out_data       = mem_read_data;
    count          = cnt;
  end

  // pointers wrap by compare so any DEPTH works
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)
        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
    end
  end

  // occupancy tracks push/pop balance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else begin
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_array_fifo_ctrl.sv
// Bench for array_fifo_ctrl with behavioural arrays.
// Runs DEPTH=4 and DEPTH=3 instances side by side.
module tb_array_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       iv;
  logic [7:0] idata;
  logic       ordy;

  logic       ir4, ov4, we4, full4, empty4;
  logic [7:0] od4, wd4, rd4;
  logic [1:0] wa4, ra4;
  logic [2:0] cnt4;

  logic       ir3, ov3, we3, full3, empty3;
  logic [7:0] od3, wd3, rd3;
  logic [1:0] wa3, ra3;
  logic [2:0] cnt3;

  logic [7:0] mem4 [4];
  logic [7:0] mem3 [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  array_fifo_ctrl #(.WIDTH(8), .DEPTH(4)) d4 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(iv), .in_ready(ir4), .in_data(idata),
    .out_valid(ov4), .out_ready(ordy), .out_data(od4),
    .mem_write_en(we4), .mem_write_addr(wa4),
    .mem_write_data(wd4), .mem_read_addr(ra4),
    .mem_read_data(rd4), .count(cnt4),
    .full(full4), .empty(empty4)
  );

  array_fifo_ctrl #(.WIDTH(8), .DEPTH(3)) d3 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(iv), .in_ready(ir3), .in_data(idata),
    .out_valid(ov3), .out_ready(ordy), .out_data(od3),
    .mem_write_en(we3), .mem_write_addr(wa3),
    .mem_write_data(wd3), .mem_read_addr(ra3),
    .mem_read_data(rd3), .count(cnt3),
    .full(full3), .empty(empty3)
  );

  always_ff @(posedge clk)
    if (we4) mem4[wa4] <= wd4;
  always_ff @(posedge clk)
    if (we3 && wa3 < 2'd3) mem3[wa3] <= wd3;

  assign rd4 = mem4[ra4];
  assign rd3 = (ra3 < 2'd3) ? mem3[ra3] : 8'hxx;

  typedef struct {
    logic       fl;
    logic       v;
    logic [7:0] d;
    logic       o;
    int         cnt;
    logic       ir;
    logic       ov;
    logic       we;
    logic       cod;
    logic [7:0] od;
  } vec_t;

  vec_t tv [18];

  task automatic chk(input string n,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask

  task automatic drive(input logic f, input logic v,
                       input logic [7:0] d, input logic o);
    @(negedge clk);
    flush = f;
    iv    = v;
    idata = d;
    ordy  = o;
    #1;
  endtask

  logic [7:0] q [$];
  int m4, m3;
  logic [7:0] exp_d;

  initial begin
    tv[0]  = '{0,1,8'h00,0, 0,1,0,1, 0,8'h00};
    tv[1]  = '{0,1,8'h22,0, 1,1,1,1, 1,8'h00};
    tv[2]  = '{0,1,8'h44,0, 2,1,1,1, 1,8'h00};
    tv[3]  = '{0,1,8'h66,0, 3,1,1,1, 1,8'h00};
    tv[4]  = '{0,1,8'hAA,0, 4,0,1,0, 1,8'h00};
    tv[5]  = '{0,0,8'h00,1, 4,0,1,0, 1,8'h00};
    tv[6]  = '{0,0,8'h00,1, 3,1,1,0, 1,8'h22};
    tv[7]  = '{0,0,8'h00,1, 2,1,1,0, 1,8'h44};
    tv[8]  = '{0,0,8'h00,1, 1,1,1,0, 1,8'h66};
    tv[9]  = '{0,0,8'h00,1, 0,1,0,0, 0,8'h00};
    tv[10] = '{0,0,8'h00,1, 0,1,0,0, 0,8'h00};
    tv[11] = '{0,1,8'h01,0, 0,1,0,1, 0,8'h00};
    tv[12] = '{0,1,8'h02,0, 1,1,1,1, 1,8'h01};
    tv[13] = '{0,1,8'h03,0, 2,1,1,1, 1,8'h01};
    tv[14] = '{1,1,8'h04,1, 3,0,0,0, 0,8'h00};
    tv[15] = '{0,1,8'h5C,0, 0,1,0,1, 0,8'h00};
    tv[16] = '{0,0,8'h00,1, 1,1,1,0, 1,8'h5C};
    tv[17] = '{0,0,8'h00,0, 0,1,0,0, 0,8'h00};

    rst_n = 1'b0;
    flush = 1'b0;
    iv    = 1'b0;
    idata = 8'h00;
    ordy  = 1'b0;
    #1;
    chk("rst.cnt", 32'(cnt4), 0);
    chk("rst.ir", 32'(ir4), 1);
    chk("rst.ov", 32'(ov4), 0);
    chk("rst.empty", 32'(empty4), 1);
    chk("rst.full", 32'(full4), 0);
    chk("rst.we", 32'(we4), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // fill, drain, flush vectors on the DEPTH=4 instance
    for (int i = 0; i < 18; i++) begin
      drive(tv[i].fl, tv[i].v, tv[i].d, tv[i].o);
      chk($sformatf("v%0d.cnt", i), 32'(cnt4), tv[i].cnt);
      chk($sformatf("v%0d.ir", i), 32'(ir4), 32'(tv[i].ir));
      chk($sformatf("v%0d.ov", i), 32'(ov4), 32'(tv[i].ov));
      chk($sformatf("v%0d.we", i), 32'(we4), 32'(tv[i].we));
      chk($sformatf("v%0d.full", i), 32'(full4),
          32'(tv[i].cnt == 4));
      chk($sformatf("v%0d.empty", i), 32'(empty4),
          32'(tv[i].cnt == 0));
      if (tv[i].cod)
        chk($sformatf("v%0d.od", i), 32'(od4), 32'(tv[i].od));
    end

    // wrap and concurrent push/pop, both depths
    drive(1, 0, 8'h00, 0);
    m4 = 0;
    m3 = 0;
    q.delete();
    for (int k = 0; k < 2; k++) begin
      drive(0, 1, 8'hF0 + 8'(k), 0);
      chk("pre.wa4", 32'(wa4), m4);
      chk("pre.wa3", 32'(wa3), m3);
      q.push_back(8'hF0 + 8'(k));
      m4 = (m4 == 3) ? 0 : m4 + 1;
      m3 = (m3 == 2) ? 0 : m3 + 1;
    end
    for (int k = 0; k < 10; k++) begin
      drive(0, 1, 8'h10 + 8'(k), 1);
      chk($sformatf("s%0d.cnt4", k), 32'(cnt4), 2);
      chk($sformatf("s%0d.cnt3", k), 32'(cnt3), 2);
      chk($sformatf("s%0d.od4", k), 32'(od4), 32'(q[0]));
      chk($sformatf("s%0d.od3", k), 32'(od3), 32'(q[0]));
      chk($sformatf("s%0d.we4", k), 32'(we4), 1);
      chk($sformatf("s%0d.wa4", k), 32'(wa4), m4);
      chk($sformatf("s%0d.wa3", k), 32'(wa3), m3);
      void'(q.pop_front());
      q.push_back(8'h10 + 8'(k));
      m4 = (m4 == 3) ? 0 : m4 + 1;
      m3 = (m3 == 2) ? 0 : m3 + 1;
    end
    drive(0, 0, 8'h00, 0);
    chk("s.end.cnt4", 32'(cnt4), 2);
    chk("s.end.cnt3", 32'(cnt3), 2);

    // backpressure at full, then one pop frees a slot
    drive(1, 0, 8'h00, 0);
    for (int k = 0; k < 4; k++)
      drive(0, 1, 8'h31 + 8'(k), 0);
    for (int k = 0; k < 5; k++) begin
      drive(0, 1, 8'hAA, 0);
      chk($sformatf("bp%0d.we", k), 32'(we4), 0);
      chk($sformatf("bp%0d.cnt", k), 32'(cnt4), 4);
      chk($sformatf("bp%0d.ir", k), 32'(ir4), 0);
    end
    drive(0, 1, 8'hAA, 1);
    chk("bp.pop.ir", 32'(ir4), 0);
    chk("bp.pop.we", 32'(we4), 0);
    chk("bp.pop.od", 32'(od4), 32'h31);
    drive(0, 1, 8'hAA, 0);
    chk("bp.acc.ir", 32'(ir4), 1);
    chk("bp.acc.we", 32'(we4), 1);
    chk("bp.acc.wd", 32'(wd4), 32'hAA);
    chk("bp.acc.cnt", 32'(cnt4), 3);
    for (int k = 0; k < 4; k++) begin
      exp_d = (k == 3) ? 8'hAA : 8'h32 + 8'(k);
      drive(0, 0, 8'h00, 1);
      chk($sformatf("bd%0d.cnt", k), 32'(cnt4), 4 - k);
      chk($sformatf("bd%0d.od", k), 32'(od4), 32'(exp_d));
    end
    drive(0, 0, 8'h00, 0);
    chk("bd.empty", 32'(empty4), 1);

    // async reset between edges
    drive(1, 0, 8'h00, 0);
    drive(0, 1, 8'h41, 0);
    drive(0, 1, 8'h42, 0);
    drive(0, 0, 8'h00, 0);
    chk("ar.pre.cnt", 32'(cnt4), 2);
    #1 rst_n = 1'b0;
    #1;
    chk("ar.cnt", 32'(cnt4), 0);
    chk("ar.ov", 32'(ov4), 0);
    chk("ar.ir", 32'(ir4), 1);
    chk("ar.empty", 32'(empty4), 1);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 1, 8'h77, 0);
    chk("ar.push.we", 32'(we4), 1);
    drive(0, 0, 8'h00, 1);
    chk("ar.rd.cnt", 32'(cnt4), 1);
    chk("ar.rd.ov", 32'(ov4), 1);
    chk("ar.rd.od", 32'(od4), 32'h77);
    drive(0, 0, 8'h00, 0);
    chk("ar.end.cnt", 32'(cnt4), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
